// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared definitions for the direct-mapped write-back data
//                cache: FSM state encoding, default geometry and helpers
//                that locate the word, index and tag fields of a byte
//                address.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default geometry: 16 lines of 4 words (16 B per line).
    localparam int c_DEF_INDEX_WIDTH  = 4;
    localparam int c_DEF_OFFSET_WIDTH = 2;

    // Byte-within-word bits are never used to select storage.
    localparam int c_WORD_LSB = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    // Lowest address bit of the line index field.
    function automatic int index_lsb(input int offset_width);
        return c_WORD_LSB + offset_width;
    endfunction

    // Lowest address bit of the tag field.
    function automatic int tag_lsb(input int offset_width, input int index_width);
        return c_WORD_LSB + offset_width + index_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Valid/dirty/tag/data storage for the data cache.
//                One combinational read port and one synchronous write port
//                sharing the same {index, word} address.
//  Ports       : clk           - clock
//                inval_all     - clear every valid and dirty bit
//                index, word   - shared read/write line and word select
//                rd_*          - line metadata and selected data word
//                wr_word_en    - write wr_data into the selected word
//                wr_set_dirty  - mark the selected line dirty
//                wr_meta_en    - install wr_tag, set valid, clear dirty
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH  = c_DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = c_DEF_OFFSET_WIDTH,
    parameter int TAG_WIDTH    = 32 - c_WORD_LSB - c_DEF_OFFSET_WIDTH - c_DEF_INDEX_WIDTH
) (
    input  logic                    clk,
    input  logic                    inval_all,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] word,
    output logic                    rd_valid,
    output logic                    rd_dirty,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic [31:0]             rd_data,
    input  logic                    wr_word_en,
    input  logic [31:0]             wr_data,
    input  logic                    wr_set_dirty,
    input  logic                    wr_meta_en,
    input  logic [TAG_WIDTH-1:0]    wr_tag
);

    localparam int c_LINES = 1 << INDEX_WIDTH;
    localparam int c_WORDS = 1 << OFFSET_WIDTH;

    logic [c_LINES-1:0]   r_valid;
    logic [c_LINES-1:0]   r_dirty;
    logic [TAG_WIDTH-1:0] r_tag  [c_LINES];
    logic [31:0]          r_data [c_LINES*c_WORDS];

    logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] w_word_addr;
    assign w_word_addr = {index, word};

    assign rd_valid = r_valid[index];
    assign rd_dirty = r_dirty[index];
    assign rd_tag   = r_tag[index];
    assign rd_data  = r_data[w_word_addr];

    // Only the state bits are reset; tags and data are qualified by valid.
    always_ff @(posedge clk) begin
        if (inval_all) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (wr_meta_en) begin
                r_valid[index] <= 1'b1;
                r_dirty[index] <= 1'b0;
            end else if (wr_set_dirty) begin
                r_dirty[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_meta_en) begin
            r_tag[index] <= wr_tag;
        end
        if (wr_word_en) begin
            r_data[w_word_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb
//  Description : Direct-mapped, write-back, write-allocate data cache between
//                the CPU MEM stage and a multi-cycle word-wide data RAM.
//                Hits complete with zero stall. A miss writes back a dirty
//                victim line word by word, fills the new line, then replays
//                the held CPU request as a hit.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                cpu_cs/we/addr/din       - CPU request (held while stalled)
//                cpu_dout, cpu_stall      - load data, request-pending flag
//                mem_cs/we/addr/din       - RAM request, one word each
//                mem_dout, mem_ack        - RAM read data, completion pulse
//                hit_cnt, miss_cnt        - statistics counters
//  Options     : DCACHE_STATS_EN - when defined, hit_cnt/miss_cnt count;
//                otherwise both are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH  = c_DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = c_DEF_OFFSET_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_WIDTH   = 32 - c_WORD_LSB - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int c_INDEX_LSB = index_lsb(OFFSET_WIDTH);
    localparam int c_TAG_LSB   = tag_lsb(OFFSET_WIDTH, INDEX_WIDTH);

    // ------------------------------------------------------------------
    // CPU address split
    // ------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]    w_cpu_tag;
    logic [INDEX_WIDTH-1:0]  w_cpu_index;
    logic [OFFSET_WIDTH-1:0] w_cpu_word;
    logic                    w_unused_addr_lsbs;

    assign w_cpu_tag          = cpu_addr[31:c_TAG_LSB];
    assign w_cpu_index        = cpu_addr[c_TAG_LSB-1:c_INDEX_LSB];
    assign w_cpu_word         = cpu_addr[c_INDEX_LSB-1:c_WORD_LSB];
    assign w_unused_addr_lsbs = ^cpu_addr[c_WORD_LSB-1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OFFSET_WIDTH-1:0] r_cnt;
    logic [OFFSET_WIDTH-1:0] w_cnt_nxt;
    logic [TAG_WIDTH-1:0]    r_miss_tag;
    logic [INDEX_WIDTH-1:0]  r_miss_index;
    logic                    w_latch;
    logic                    w_last;

    // ------------------------------------------------------------------
    // Storage. In S_IDLE the array is addressed by the live CPU request;
    // during a miss it is addressed by the latched index and word counter,
    // so the victim tag/data stay visible throughout write-back.
    // ------------------------------------------------------------------
    logic                    w_idle;
    logic [INDEX_WIDTH-1:0]  w_arr_index;
    logic [OFFSET_WIDTH-1:0] w_arr_word;
    logic [31:0]             w_arr_wdata;
    logic                    w_rd_valid;
    logic                    w_rd_dirty;
    logic [TAG_WIDTH-1:0]    w_rd_tag;
    logic [31:0]             w_rd_data;
    logic                    w_wr_word_en;
    logic                    w_wr_set_dirty;
    logic                    w_wr_meta_en;
    logic                    w_hit;

    assign w_idle      = (r_state == S_IDLE);
    assign w_arr_index = w_idle ? w_cpu_index : r_miss_index;
    assign w_arr_word  = w_idle ? w_cpu_word  : r_cnt;
    assign w_arr_wdata = w_idle ? cpu_din     : mem_dout;

    dcache_array #(
        .INDEX_WIDTH  (INDEX_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .TAG_WIDTH    (TAG_WIDTH)
    ) u_array (
        .clk          (clk),
        .inval_all    (rst),
        .index        (w_arr_index),
        .word         (w_arr_word),
        .rd_valid     (w_rd_valid),
        .rd_dirty     (w_rd_dirty),
        .rd_tag       (w_rd_tag),
        .rd_data      (w_rd_data),
        .wr_word_en   (w_wr_word_en   & ~rst),
        .wr_data      (w_arr_wdata),
        .wr_set_dirty (w_wr_set_dirty & ~rst),
        .wr_meta_en   (w_wr_meta_en   & ~rst),
        .wr_tag       (r_miss_tag)
    );

    assign w_hit     = cpu_cs & w_idle & w_rd_valid & (w_rd_tag == w_cpu_tag);
    assign cpu_stall = cpu_cs & ~w_hit;
    assign cpu_dout  = w_hit ? w_rd_data : 32'h0;
    assign w_last    = &r_cnt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_miss_tag   <= w_cpu_tag;
            r_miss_index <= w_cpu_index;
        end
    end

    // mem_addr/mem_din depend only on registered state and the counter,
    // so within a burst they move only at the edge that consumes mem_ack.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_wr_word_en   = 1'b0;
        w_wr_set_dirty = 1'b0;
        w_wr_meta_en   = 1'b0;
        mem_cs         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'h0;
        mem_din        = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    if (cpu_we) begin
                        w_wr_word_en   = 1'b1;
                        w_wr_set_dirty = 1'b1;
                    end
                end else if (cpu_cs) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_rd_valid && w_rd_dirty) ? S_WB : S_FILL;
                end
            end

            S_WB: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {w_rd_tag, r_miss_index, r_cnt, 2'b00};
                mem_din  = w_rd_data;
                if (mem_ack) begin
                    // Counter wraps to zero after the last word, ready for the fill.
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_FILL;
                    end
                end
            end

            S_FILL: begin
                mem_cs   = 1'b1;
                mem_addr = {r_miss_tag, r_miss_index, r_cnt, 2'b00};
                if (mem_ack) begin
                    w_wr_word_en = 1'b1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    if (w_last) begin
                        w_wr_meta_en = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_replay;

    // r_replay marks the first S_IDLE cycle after a fill, where the held
    // request hits again; that replay must not count as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= 32'h0;
            r_miss_cnt <= 32'h0;
            r_replay   <= 1'b0;
        end else begin
            if (w_hit && !r_replay) begin
                r_hit_cnt <= r_hit_cnt + 32'h1;
            end
            if (w_latch) begin
                r_miss_cnt <= r_miss_cnt + 32'h1;
            end
            r_replay <= w_wr_meta_en;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 32'h0;
    assign miss_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_wb
//  Description : Self-checking bench for dcache_wb. A behavioural RAM with a
//                four-cycle ack sits on the memory side. The reference is a
//                flat CPU-visible memory plus per-line residency records,
//                from which stall lengths, RAM traffic and load data are
//                predicted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_din = 32'h0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // ------------------------------------------------------------------
    // RAM: each word completes on the 4th cycle of mem_cs.
    // ------------------------------------------------------------------
    logic [31:0] ram [0:4095];
    int unsigned ram_wait = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0100_0193);
    endfunction

    assign mem_ack  = mem_cs && (ram_wait == 3);
    assign mem_dout = mem_ack ? ram[mem_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst || !mem_cs) begin
            ram_wait <= 0;
        end else if (ram_wait == 3) begin
            ram_wait <= 0;
            if (mem_we) ram[mem_addr[13:2]] <= mem_din;
        end else begin
            ram_wait <= ram_wait + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t trans_q[$];
    txn_t exp_q[$];

    always @(negedge clk) begin : mon
        txn_t t;
        if (mem_ack && !rst) begin
            t.we   = mem_we;
            t.addr = mem_addr;
            t.data = mem_we ? mem_din : mem_dout;
            trans_q.push_back(t);
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] model_mem [0:4095];
    bit          mvalid [16];
    bit          mdirty [16];
    logic [23:0] mtag   [16];
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        // Dirty lines are lost by reset, so the CPU view reverts to RAM.
        for (int i = 0; i < 4096; i++) model_mem[i] = ram[i];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Predict stall length and RAM traffic for an access, and update the
    // residency record as if the line were now resident.
    task automatic predict(input logic [31:0] addr, output int stall, output bit hit);
        int          idx;
        logic [23:0] t;
        logic [31:0] a;
        txn_t        e;
        idx = int'(addr[7:4]);
        t   = addr[31:8];
        exp_q.delete();
        hit = mvalid[idx] && (mtag[idx] == t);
        stall = 0;
        if (!hit) begin
            stall = 17;
            if (mvalid[idx] && mdirty[idx]) begin
                stall = 33;
                for (int w = 0; w < 4; w++) begin
                    a = {mtag[idx], 4'(idx), 2'(w), 2'b00};
                    e.we = 1'b1; e.addr = a; e.data = model_mem[a[13:2]];
                    exp_q.push_back(e);
                end
            end
            for (int w = 0; w < 4; w++) begin
                a = {t, 4'(idx), 2'(w), 2'b00};
                e.we = 1'b0; e.addr = a; e.data = model_mem[a[13:2]];
                exp_q.push_back(e);
            end
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            mtag[idx]   = t;
            exp_misses++;
        end
    endtask

    task automatic check_traffic(input int start);
        check("txn_count", 32'(trans_q.size() - start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < trans_q.size()) begin
                check("txn_we",   {31'b0, trans_q[start+i].we}, {31'b0, exp_q[i].we});
                check("txn_addr", trans_q[start+i].addr, exp_q[i].addr);
                check("txn_data", trans_q[start+i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic check_counters();
        check("hit_cnt",  hit_cnt,  STATS ? 32'(exp_hits)   : 32'h0);
        check("miss_cnt", miss_cnt, STATS ? 32'(exp_misses) : 32'h0);
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data);
        int stall_exp;
        int cycles;
        int start;
        bit hit;
        predict(addr, stall_exp, hit);
        start = trans_q.size();
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = data;
        #1;
        if (!hit) check("dout_on_miss", cpu_dout, 32'h0);
        cycles = 0;
        while (cpu_stall === 1'b1 && cycles < 100) begin
            @(posedge clk); #2;
            cycles++;
        end
        check("stall_cycles", 32'(cycles), 32'(stall_exp));
        check("mem_cs_done", {31'b0, mem_cs}, 32'h0);
        if (!we) check("load_data", cpu_dout, model_mem[addr[13:2]]);
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_we = 1'b0;
        if (hit) exp_hits++;
        if (we) begin
            model_mem[addr[13:2]] = data;
            mdirty[addr[7:4]]     = 1'b1;
        end
        #1;
        check_traffic(start);
        check_counters();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cpu_cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin : main
        int          start;
        int          cycles;
        int          stall_exp;
        bit          hit;
        logic [31:0] a;

        for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
        #1;

        // Reset state
        do_reset();
        #1;
        check("rst_stall",    {31'b0, cpu_stall}, 32'h0);
        check("rst_mem_cs",   {31'b0, mem_cs},    32'h0);
        check("rst_mem_we",   {31'b0, mem_we},    32'h0);
        check("rst_mem_addr", mem_addr,           32'h0);
        check("rst_mem_din",  mem_din,            32'h0);
        check("rst_dout",     cpu_dout,           32'h0);
        check_counters();

        // Clean load miss, then hit in the same line
        access(1'b0, 32'h0000_0100, 32'h0);
        access(1'b0, 32'h0000_0104, 32'h0);
        // Store hit makes the line dirty; conflicting load forces write-back
        access(1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0508, 32'h0);
        // Store miss to a clean line, then load it back
        access(1'b1, 32'h0000_0200, 32'h1234_5678);
        access(1'b0, 32'h0000_0200, 32'h0);

        // Reset during the second word of a fill
        start = trans_q.size();
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0310;
        #1;
        cycles = 0;
        while (trans_q.size() < start + 1 && cycles < 100) begin
            @(posedge clk); #2;
            cycles++;
        end
        check("rstfill_first_ack", 32'(trans_q.size() - start), 32'h1);
        rst = 1'b1; cpu_cs = 1'b0;
        @(posedge clk); #2;
        check("rstfill_mem_cs", {31'b0, mem_cs},    32'h0);
        check("rstfill_stall",  {31'b0, cpu_stall}, 32'h0);
        rst = 1'b0;
        model_reset();
        #1;
        check_counters();
        access(1'b0, 32'h0000_0310, 32'h0);

        // CPU drops its request mid-fill; the fill still completes
        predict(32'h0000_0420, stall_exp, hit);
        start = trans_q.size();
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0420;
        #1;
        cycles = 0;
        while (trans_q.size() < start + 1 && cycles < 100) begin
            @(posedge clk); #2;
            cycles++;
        end
        cpu_cs = 1'b0;
        #1;
        check("drop_stall", {31'b0, cpu_stall}, 32'h0);
        cycles = 0;
        while (trans_q.size() < start + 4 && cycles < 100) begin
            @(posedge clk); #2;
            cycles++;
        end
        @(posedge clk); #2;
        check("drop_mem_cs", {31'b0, mem_cs}, 32'h0);
        check_traffic(start);
        check_counters();
        access(1'b0, 32'h0000_0420, 32'h0);

        // Random traffic over a few indices and many tags to force conflicts
        for (int n = 0; n < 80; n++) begin
            a = {20'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the multi-cycle word-wide data RAM.
- CPU side: read and write hits complete with zero stall.
- Memory side: drives the RAM's cs/we/addr/din handshake one word per transaction and waits for ack on each.
- Misses write back a dirty victim line, then fill the new line, then service the held CPU request.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (16 lines).
- OFFSET_WIDTH, 2, log2 of words per line (4 words = 16 B).
- TAG_WIDTH, 32-2-OFFSET_WIDTH-INDEX_WIDTH, derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_cs  in  1  CPU memory request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data, valid when cpu_cs & ~cpu_we & ~cpu_stall.
- cpu_stall  out  1  request not yet complete; CPU holds all cpu_* inputs stable.
- mem_cs  out  1  RAM request.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM byte address, word-aligned.
- mem_din  out  32  write-back data to RAM.
- mem_dout  in  32  RAM read data, valid with mem_ack.
- mem_ack  in  1  RAM completion, one-cycle pulse.
- hit_cnt  out  32  hit count (see Optional Feature).
- miss_cnt  out  32  miss count (see Optional Feature).

Behaviour:
- Address split: tag = addr[31:2+OFFSET_WIDTH+INDEX_WIDTH], index = next INDEX_WIDTH bits, word = addr[2+OFFSET_WIDTH-1:2].
- Storage per line: valid, dirty, tag, 2^OFFSET_WIDTH data words.
- hit = cpu_cs & valid[index] & (tag match), combinational, evaluated in S_IDLE only.
- cpu_stall = cpu_cs & ~(state==S_IDLE & hit). Reset value 0.
- cpu_dout: the hit word; 0 when no hit.
- Read hit: data valid in the same cycle; no state change.
- Write hit: word written and dirty set at the posedge of that cycle.
- FSM states:
  - S_IDLE. On cpu_cs & ~hit: if valid & dirty go to S_WB, else go to S_FILL. In both cases word counter cnt=0 and the miss address is latched.
  - S_WB. mem_cs=1, mem_we=1, mem_addr = {victim tag, index, cnt, 2'b00}, mem_din = line word cnt. On mem_ack: cnt+1; after the last word, cnt=0 and go to S_FILL.
  - S_FILL. mem_cs=1, mem_we=0, mem_addr = {latched tag, index, cnt, 2'b00}. On mem_ack: write mem_dout into word cnt, cnt+1. After the last word: set tag, valid=1, dirty=0, go to S_IDLE.
- Back in S_IDLE the request now hits and completes normally; a store sets dirty then.
- mem_cs stays high across consecutive words. mem_addr and mem_din change only at the edge where mem_ack=1 is sampled.
- mem_* reset values: 0. mem_cs=0 in S_IDLE.
- Miss latency (clean line): 4 words x 4 RAM cycles plus 1 = 17 cycles. Dirty line: 33 cycles.
- A miss sequence, once started, always completes, even if cpu_cs drops. Memory transactions are never aborted.
- If cpu_cs is low on return to S_IDLE, nothing further happens.
- cpu_addr is sampled only in S_IDLE; a changed cpu_addr mid-miss is ignored until S_IDLE.
- Reset (any state, including mid-miss): state=S_IDLE, cnt=0, all valid and dirty bits cleared, mem_cs=0. Data and tag arrays are not cleared.
- The counter cnt is OFFSET_WIDTH bits wide; the last word is detected by cnt all-ones, with no overflow past the line.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: hit_cnt and miss_cnt increment as follows, both wrap at 2^32, both cleared by rst.
  - hit_cnt: once per completed request that hit on its first S_IDLE cycle.
  - miss_cnt: once per S_IDLE->S_WB or S_IDLE->S_FILL transition.
  - The replay hit after a fill does not count toward hit_cnt.
- Undefined: both outputs tied to 0, no counter logic.

Decomposition:
- Shared package dcache_pkg holds:
  - state encodings S_IDLE=0, S_WB=1, S_FILL=2 (2-bit state_t);
  - default INDEX_WIDTH and OFFSET_WIDTH;
  - helper constants for the tag, index and word bit positions.
- One natural sub-module: dcache_array, the valid/dirty/tag/data storage with a combinational read port and a single synchronous write port (word write, line-metadata write, invalidate-all).
- The FSM and address muxing stay in dcache_wb.

Test Plan:
- After rst, load 0x100 -> miss; mem reads 0x100, 0x104, 0x108, 0x10C; cpu_stall high for 17 cycles; cpu_dout = RAM[0x100]; miss_cnt=1.
- Load 0x104 right after -> hit, cpu_stall=0, no mem_cs, hit_cnt=1.
- Store 0xDEADBEEF to 0x108 (hit), then load 0x508 (same index, new tag):
  - 4 writes to 0x100..0x10C with 0xDEADBEEF at 0x108;
  - then 4 reads from 0x500..0x50C;
  - 33 stall cycles total.
- Store miss to 0x200 (clean line): fill 0x200..0x20C, then store 0x12345678 at the replay. A later load 0x200 returns 0x12345678 with no stall.
- rst asserted during the 2nd word of S_FILL: next cycle mem_cs=0, state S_IDLE. A reload of the same address misses again and does a full fill.
- cpu_cs dropped mid-fill: fill completes with 4 acks. Re-request of the same address hits with zero stall.
